// File: rtl/power_mode_sequencer.sv
// -----------------------------------------------------------------------------
// power_mode_sequencer
//
// Autonomous power-mode scheduler for the sensor controller's clock-gating /
// power block. It watches the global idle count and the wakeup sources and
// walks the chip through NORMAL -> LOW -> SLEEP -> DEEP. Before entering SLEEP
// it runs a drain handshake with the framer/transmitter. On wakeup it holds a
// settle window and disarms automatic entry until fresh idleness is observed.
//
// Ports:
//   clk               in   system clock
//   rst               in   asynchronous active-high reset
//   global_enable     in   0 forces NORMAL and disarms automatic entry
//   auto_en           in   permits automatic low-power entry
//   mode_cap[1:0]     in   deepest mode allowed (00 NORMAL .. 11 DEEP)
//   idle_counter[15:0]in   global idle count (saturating)
//   system_wakeup     in   hardware wake pulse
//   host_wake         in   software wake request
//   drain_ack         in   framer/tx flushed and idle
//   err_clr           in   clears drain_timeout_err
//   power_mode[1:0]   out  mode driven to the power block
//   drain_req         out  flush request to framer/tx
//   mode_change       out  one-cycle pulse after power_mode changes
//   wake_ready        out  one-cycle pulse on the first NORMAL cycle after WAKE
//   seq_state[2:0]    out  current FSM state (debug)
//   drain_timeout_err out  sticky drain-timeout flag
// -----------------------------------------------------------------------------
module power_mode_sequencer #(
    parameter logic [15:0] LOW_THRESH    = 16'd1000,
    parameter logic [15:0] SLEEP_THRESH  = 16'd8000,
    parameter logic [15:0] DEEP_THRESH   = 16'hF000,
    parameter logic [7:0]  DRAIN_TIMEOUT = 8'd64,
    parameter logic [3:0]  WAKE_SETTLE   = 4'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        global_enable,
    input  logic        auto_en,
    input  logic [1:0]  mode_cap,
    input  logic [15:0] idle_counter,
    input  logic        system_wakeup,
    input  logic        host_wake,
    input  logic        drain_ack,
    input  logic        err_clr,
    output logic [1:0]  power_mode,
    output logic        drain_req,
    output logic        mode_change,
    output logic        wake_ready,
    output logic [2:0]  seq_state,
    output logic        drain_timeout_err
);

    typedef enum logic [2:0] {
        ST_NORMAL = 3'd0,
        ST_LOW    = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_SLEEP  = 3'd3,
        ST_DEEP   = 3'd4,
        ST_WAKE   = 3'd5
    } state_t;

    state_t      state_q,       state_d;
    logic        armed_q,       armed_d;
    logic [7:0]  drain_cnt_q,   drain_cnt_d;
    logic [3:0]  settle_cnt_q,  settle_cnt_d;
    logic [1:0]  power_mode_q,  power_mode_d;
    logic        drain_req_q,   drain_req_d;
    logic        mode_change_q, mode_change_d;
    logic        wake_ready_q,  wake_ready_d;
    logic        err_q,         err_d;

    logic        wake_evt;
    logic        entry_ok;
    logic        below_low;
    logic        err_set;

    assign wake_evt  = system_wakeup | host_wake;
    assign entry_ok  = auto_en & armed_q;
    assign below_low = (idle_counter < LOW_THRESH);

    // -------------------------------------------------------------------------
    // Next-state, counters and output decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        armed_d      = armed_q;
        drain_cnt_d  = '0;
        settle_cnt_d = '0;
        wake_ready_d = 1'b0;
        err_set      = 1'b0;

        if (!global_enable) begin
            state_d = ST_NORMAL;
            armed_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (below_low) begin
                        armed_d = 1'b1;
                    end else if (mode_cap != 2'b00 && entry_ok) begin
                        state_d = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (mode_cap == 2'b00 || below_low) begin
                        state_d = ST_NORMAL;
                    end else if (idle_counter >= SLEEP_THRESH && mode_cap[1] && entry_ok) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Ack outranks the timeout when both land on the same cycle.
                    if (wake_evt) begin
                        state_d = ST_WAKE;
                    end else if (drain_ack) begin
                        state_d = ST_SLEEP;
                    end else if (drain_cnt_q == DRAIN_TIMEOUT - 8'd1) begin
                        state_d = ST_NORMAL;
                        err_set = 1'b1;
                        armed_d = 1'b0;
                    end else begin
                        drain_cnt_d = drain_cnt_q + 8'd1;
                    end
                end
                ST_SLEEP: begin
                    if (wake_evt || !mode_cap[1]) begin
                        state_d = ST_WAKE;
                    end else if (idle_counter >= DEEP_THRESH && mode_cap == 2'b11 && entry_ok) begin
                        state_d = ST_DEEP;
                    end
                end
                ST_DEEP: begin
                    if (wake_evt || mode_cap != 2'b11) begin
                        state_d = ST_WAKE;
                    end
                end
                ST_WAKE: begin
                    // Wake inputs are deliberately not looked at here.
                    if (settle_cnt_q == WAKE_SETTLE - 4'd1) begin
                        state_d      = ST_NORMAL;
                        wake_ready_d = 1'b1;
                    end else begin
                        settle_cnt_d = settle_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_NORMAL;
                end
            endcase

            // Any entry into WAKE disarms automatic entry until idle drops.
            if (state_d == ST_WAKE && state_q != ST_WAKE) begin
                armed_d = 1'b0;
            end
        end

        // Outputs are decoded from the next state so they settle one edge
        // after the condition that caused them.
        unique case (state_d)
            ST_LOW:   power_mode_d = 2'b01;
            ST_SLEEP: power_mode_d = 2'b10;
            ST_DEEP:  power_mode_d = 2'b11;
            ST_DRAIN: power_mode_d = power_mode_q;   // keep the mode drain began in
            default:  power_mode_d = 2'b00;          // NORMAL and WAKE
        endcase

        drain_req_d   = (state_d == ST_DRAIN);
        mode_change_d = (power_mode_d != power_mode_q);
        // A new timeout outranks a simultaneous clear.
        err_d         = err_set | (err_q & ~err_clr);
    end

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q       <= ST_NORMAL;
            armed_q       <= 1'b1;
            drain_cnt_q   <= '0;
            settle_cnt_q  <= '0;
            power_mode_q  <= 2'b00;
            drain_req_q   <= 1'b0;
            mode_change_q <= 1'b0;
            wake_ready_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            drain_cnt_q   <= drain_cnt_d;
            settle_cnt_q  <= settle_cnt_d;
            power_mode_q  <= power_mode_d;
            drain_req_q   <= drain_req_d;
            mode_change_q <= mode_change_d;
            wake_ready_q  <= wake_ready_d;
            err_q         <= err_d;
        end
    end

    assign power_mode        = power_mode_q;
    assign drain_req         = drain_req_q;
    assign mode_change       = mode_change_q;
    assign wake_ready        = wake_ready_q;
    assign seq_state         = state_q;
    assign drain_timeout_err = err_q;

endmodule

// File: doc/power_mode_sequencer.md
# power_mode_sequencer

Autonomous power-mode scheduler feeding the `power_mode[1:0]` input of the sensor controller's clock-gating/power block. It watches the global idle count and wakeup sources and walks the chip through NORMAL → LOW → SLEEP → DEEP. Before any sleep entry it runs a drain handshake with the framer/transmitter. On wakeup it enforces a settle window and re-arming hysteresis so the chip does not re-enter low power immediately.

## Interface
Parameters:
- `LOW_THRESH`, 16'd1000: idle cycles required to enter LOW.
- `SLEEP_THRESH`, 16'd8000: idle cycles required to start the drain toward SLEEP; must be > `LOW_THRESH`.
- `DEEP_THRESH`, 16'hF000: idle cycles required to go from SLEEP to DEEP; must be > `SLEEP_THRESH`.
- `DRAIN_TIMEOUT`, 8'd64: maximum number of cycles spent waiting for `drain_ack`.
- `WAKE_SETTLE`, 4'd4: number of cycles spent in the WAKE state before returning to NORMAL.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `global_enable`, in, 1: sequencer enable; when 0 the block is forced to NORMAL.
- `auto_en`, in, 1: permits automatic low-power entry.
- `mode_cap`, in, 2: deepest mode allowed (00 = NORMAL … 11 = DEEP).
- `idle_counter`, in, 16: global idle count from the power block.
- `system_wakeup`, in, 1: hardware wake pulse.
- `host_wake`, in, 1: software wake request (level or pulse).
- `drain_ack`, in, 1: framer/tx report that they are idle and flushed.
- `err_clr`, in, 1: clears `drain_timeout_err`.
- `power_mode`, out, 2: mode driven to the power block.
- `drain_req`, out, 1: request to the framer/tx to flush.
- `mode_change`, out, 1: one-cycle pulse whenever `power_mode` changes.
- `wake_ready`, out, 1: one-cycle pulse on leaving WAKE.
- `seq_state`, out, 3: current FSM state, for debug.
- `drain_timeout_err`, out, 1: sticky drain-timeout flag.

## Operation
- States and encodings: NORMAL = 0, LOW = 1, DRAIN = 2, SLEEP = 3, DEEP = 4, WAKE = 5.
- `power_mode` per state:
  - NORMAL: 00; LOW: 01; SLEEP: 10; DEEP: 11; WAKE: 00.
  - DRAIN: holds the mode of the state DRAIN was entered from.
- `armed` flag:
  - Set to 1 by reset.
  - Cleared on entry to WAKE and whenever `global_enable` = 0.
  - Set again in NORMAL once `idle_counter < LOW_THRESH` is sampled.
  - Automatic entry into any low-power state requires `auto_en & armed`.
- Transition priority, evaluated every cycle, highest first:
  1. `global_enable` = 0 → NORMAL, `drain_req` = 0, drain counter cleared.
  2. `system_wakeup | host_wake` while in DRAIN, SLEEP or DEEP → WAKE. In NORMAL or LOW these inputs are ignored.
  3. Cap violation:
     - In LOW with `mode_cap` = 00 → NORMAL.
     - In SLEEP or DEEP with `mode_cap` below the current mode → WAKE.
  4. Threshold rules:
     - NORMAL → LOW when `idle_counter >= LOW_THRESH` and `mode_cap >= 01`.
     - LOW → NORMAL when `idle_counter < LOW_THRESH`.
     - LOW → DRAIN when `idle_counter >= SLEEP_THRESH` and `mode_cap >= 10`.
     - SLEEP → DEEP when `idle_counter >= DEEP_THRESH` and `mode_cap` = 11. No drain is performed for this step.
- DRAIN state:
  - `drain_req` = 1 and the drain counter increments each cycle.
  - `drain_ack` = 1 → SLEEP.
  - If the counter reaches `DRAIN_TIMEOUT` without an ack:
    - Set `drain_timeout_err`.
    - Go to NORMAL.
    - Clear `armed` so a retry waits for fresh idleness.
  - If `drain_ack` and timeout occur in the same cycle, the ack wins.
- WAKE state:
  - The settle counter counts 0 … `WAKE_SETTLE`-1, then the FSM goes to NORMAL and `wake_ready` pulses.
  - Wake inputs arriving during WAKE are ignored.
- `drain_timeout_err`:
  - Cleared by `err_clr`.
  - If set and clear occur in the same cycle, set wins.
- The idle comparison is unsigned 16-bit. `idle_counter` saturates at FFFF and needs no wrap handling.

## Timing
- Every output is registered and decoded from the next state. A condition sampled at edge N produces the new `power_mode`, `drain_req`, `seq_state` and `mode_change` after edge N, i.e. 1-cycle latency.
- `mode_change` is high for exactly the one cycle after `power_mode` changes value. A DRAIN abort back to NORMAL from LOW counts as a change.
- `drain_req` is asserted from the first DRAIN cycle and stays high until the cycle after `drain_ack` is sampled or the timeout fires. The ack may arrive in the first DRAIN cycle.
- Timeout: `drain_ack` never arriving gives `DRAIN_TIMEOUT` cycles in DRAIN, then the exit edge.
- WAKE dwell is exactly `WAKE_SETTLE` cycles. `wake_ready` is coincident with the first cycle of NORMAL.
- Reset values (asynchronous, on `rst` = 1): state NORMAL, `power_mode` 00, `drain_req` 0, `mode_change` 0, `wake_ready` 0, `seq_state` 0, `drain_timeout_err` 0, `armed` 1, all counters 0.
- Reset asserted mid-DRAIN or mid-WAKE aborts immediately with no pulse outputs.

## Test plan
- **Ramp to LOW and SLEEP:** `auto_en` = 1, cap = 11, ramp `idle_counter` 0 → 8000 with `drain_ack` tied high.
  - `power_mode` goes 00 → 01 one cycle after 1000 is seen.
  - At 8000: one DRAIN cycle, then 10.
  - `mode_change` pulses twice.
- **Drain timeout:** in LOW, drive `idle_counter` = 8000 and `drain_ack` = 0.
  - `drain_req` is high for 64 cycles, then `power_mode` = 00 and `drain_timeout_err` = 1.
  - Re-entry is blocked until `idle_counter` < 1000 is seen.
- **Wake from DEEP:** reach DEEP (`idle_counter` = F000), then pulse `system_wakeup`.
  - `power_mode` = 00 next cycle.
  - `seq_state` = 5 for 4 cycles, then `wake_ready` pulses.
  - With `idle_counter` still F000, the block stays in NORMAL (not armed).
- **Cap reduction:** in SLEEP, set `mode_cap` = 01.
  - WAKE, then NORMAL.
  - No return to LOW until the counter has dropped below 1000 and re-crossed it.
- **Simultaneous events:** in DRAIN, assert `drain_ack` and `host_wake` in the same cycle → WAKE. Separately, `drain_ack` on the timeout cycle → SLEEP with no error flag.
- **Enable and reset abort:** drop `global_enable` in SLEEP → `power_mode` = 00 next cycle. Assert `rst` mid-DRAIN → all outputs at reset values asynchronously.
